// File: rtl/arith_unit_seq_if.sv
// Request/response bus of arith_unit_seq: master issues start/op/a/b,
// slave returns the registered result and status flags.
interface arith_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             err;
    logic             done;
    logic             busy;

    modport master (
        output start, op, a, b,
        input  result, carry, overflow, err, done, busy
    );

    modport slave (
        input  start, op, a, b,
        output result, carry, overflow, err, done, busy
    );
endinterface

// File: rtl/arith_unit_seq.sv
// Sequential arithmetic unit: ADD/SUB/AND/OR/XOR/SLT in one EXEC cycle; MUL by
// WIDTH-step shift-add only when ARITH_UNIT_SEQ_MUL_EN is defined (else op 110 is invalid).
module arith_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    arith_unit_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        EXEC
`ifdef ARITH_UNIT_SEQ_MUL_EN
        ,
        MUL
`endif
    } state_t;

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             err_r;
    logic             done_r;
    logic             busy_r;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;

`ifdef ARITH_UNIT_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic               is_mul;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      step;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // prod = {accumulator, remaining multiplier bits}; each step adds a
    // into the upper half when the current LSB is set, then shifts right.
    always_comb begin
        mul_addend = prod[0] ? a_r : '0;
        mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, prod[WIDTH-1:1]};
    end
`endif

    always_comb begin
        add_ext   = {1'b0, a_r} + {1'b0, b_r};
        sub_res   = a_r - b_r;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
`ifdef ARITH_UNIT_SEQ_MUL_EN
        is_mul    = 1'b0;
`endif
        case (op_r)
            3'b000: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                            (add_ext[WIDTH-1] != a_r[WIDTH-1]);
            end
            3'b001: begin
                alu_res   = sub_res;
                alu_carry = (a_r < b_r);
                alu_ovf   = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != a_r[WIDTH-1]);
            end
            3'b010: alu_res = a_r & b_r;
            3'b011: alu_res = a_r | b_r;
            3'b100: alu_res = a_r ^ b_r;
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
`ifdef ARITH_UNIT_SEQ_MUL_EN
            3'b110: is_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            result_r   <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LATCH;
                        busy_r <= 1'b1;
                    end
                end
                LATCH: begin
                    op_r   <= bus.op;
                    a_r    <= bus.a;
                    b_r    <= bus.b;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    state  <= EXEC;
                end
                EXEC: begin
`ifdef ARITH_UNIT_SEQ_MUL_EN
                    if (is_mul) begin
                        prod  <= {{WIDTH{1'b0}}, b_r};
                        step  <= '0;
                        state <= MUL;
                    end else
`endif
                    begin
                        result_r   <= alu_res;
                        carry_r    <= alu_carry;
                        overflow_r <= alu_ovf;
                        err_r      <= alu_err;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state      <= IDLE;
                    end
                end
`ifdef ARITH_UNIT_SEQ_MUL_EN
                MUL: begin
                    prod <= mul_next;
                    step <= step + CW'(1);
                    if (step == LAST_STEP) begin
                        result_r   <= mul_next[WIDTH-1:0];
                        carry_r    <= |mul_next[2*WIDTH-1:WIDTH];
                        overflow_r <= 1'b0;
                        err_r      <= 1'b0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state      <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result   = result_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
    assign bus.err      = err_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq: a 32-bit and an 8-bit instance, a transaction-level
// model compared every cycle, plus directed vectors with literal expectations.
module tb_arith_unit_seq;

    localparam int W0 = 32;
    localparam int W1 = 8;
`ifdef ARITH_UNIT_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arith_unit_seq_if #(.WIDTH(W0)) bus0 ();
    arith_unit_seq_if #(.WIDTH(W1)) bus1 ();

    arith_unit_seq #(.WIDTH(W0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    arith_unit_seq #(.WIDTH(W1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int checks   = 0;
    int failures = 0;

    // ---------------- accessors ----------------
    function automatic logic [63:0] f_res(input int i);
        return (i == 0) ? {32'b0, bus0.result} : {56'b0, bus1.result};
    endfunction
    function automatic logic f_c(input int i);
        return (i == 0) ? bus0.carry : bus1.carry;
    endfunction
    function automatic logic f_ov(input int i);
        return (i == 0) ? bus0.overflow : bus1.overflow;
    endfunction
    function automatic logic f_err(input int i);
        return (i == 0) ? bus0.err : bus1.err;
    endfunction
    function automatic logic f_done(input int i);
        return (i == 0) ? bus0.done : bus1.done;
    endfunction
    function automatic logic f_busy(input int i);
        return (i == 0) ? bus0.busy : bus1.busy;
    endfunction

    // ---------------- reference arithmetic ----------------
    function automatic void ref_op(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int w,
                                   output logic [63:0] res, output logic c,
                                   output logic ov, output logic err);
        logic [63:0] mask;
        logic [63:0] s;
        longint sa;
        longint sb;
        mask = (64'd1 << w) - 64'd1;
        res = '0; c = 1'b0; ov = 1'b0; err = 1'b0;
        case (op)
            3'd0: begin
                s   = a + b;
                res = s & mask;
                c   = s[w];
                ov  = (a[w-1] == b[w-1]) && (res[w-1] != a[w-1]);
            end
            3'd1: begin
                res = (a - b) & mask;
                c   = (a < b);
                ov  = (a[w-1] != b[w-1]) && (res[w-1] != a[w-1]);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
                sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
                res = (sa < sb) ? 64'd1 : 64'd0;
            end
            3'd6: begin
                if (MUL_EN) begin
                    s   = a * b;
                    res = s & mask;
                    c   = (s >> w) != 64'd0;
                end else begin
                    err = 1'b1;
                end
            end
            default: err = 1'b1;
        endcase
    endfunction

    // ---------------- transaction-level model ----------------
    // stage: 0 idle, 1 accepted (operands captured next edge), 2 executing
    int          stage  [2];
    int          remain [2];
    logic [2:0]  q_op   [2];
    logic [63:0] q_a    [2];
    logic [63:0] q_b    [2];
    logic [63:0] m_res  [2];
    logic        m_c    [2];
    logic        m_ov   [2];
    logic        m_err  [2];
    logic        m_done [2];
    logic        m_busy [2];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        st;
            logic [2:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            int          w;
            w  = (i == 0) ? W0 : W1;
            st = (i == 0) ? bus0.start : bus1.start;
            op = (i == 0) ? bus0.op : bus1.op;
            a  = (i == 0) ? {32'b0, bus0.a} : {56'b0, bus1.a};
            b  = (i == 0) ? {32'b0, bus0.b} : {56'b0, bus1.b};
            if (reset) begin
                stage[i] = 0; remain[i] = 0;
                m_res[i] = '0; m_c[i] = 0; m_ov[i] = 0; m_err[i] = 0;
                m_done[i] = 0; m_busy[i] = 0;
            end else if (stage[i] == 0) begin
                if (st) begin
                    stage[i]  = 1;
                    m_busy[i] = 1'b1;
                end
            end else if (stage[i] == 1) begin
                q_op[i] = op; q_a[i] = a; q_b[i] = b;
                m_done[i] = 1'b0; m_err[i] = 1'b0;
                remain[i] = (op == 3'd6 && MUL_EN) ? 1 + w : 1;
                stage[i]  = 2;
            end else begin
                remain[i]--;
                if (remain[i] == 0) begin
                    ref_op(q_op[i], q_a[i], q_b[i], w, m_res[i], m_c[i], m_ov[i], m_err[i]);
                    m_done[i] = 1'b1;
                    m_busy[i] = 1'b0;
                    stage[i]  = 0;
                end
            end
        end
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (f_res(i) !== m_res[i] || f_c(i) !== m_c[i] || f_ov(i) !== m_ov[i] ||
                    f_err(i) !== m_err[i] || f_done(i) !== m_done[i] || f_busy(i) !== m_busy[i]) begin
                    failures++;
                    $display("FAIL model_cmp u%0d t=%0t got res=%h c=%b ov=%b err=%b done=%b busy=%b want res=%h c=%b ov=%b err=%b done=%b busy=%b",
                             i, $time, f_res(i), f_c(i), f_ov(i), f_err(i), f_done(i), f_busy(i),
                             m_res[i], m_c[i], m_ov[i], m_err[i], m_done[i], m_busy[i]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic st, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (i == 0) begin
            bus0.start = st; bus0.op = op; bus0.a = a[31:0]; bus0.b = b[31:0];
        end else begin
            bus1.start = st; bus1.op = op; bus1.a = a[7:0]; bus1.b = b[7:0];
        end
    endtask

    // Returns at the negedge after the LATCH edge; inputs are then scrambled.
    task automatic issue(input int i, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        drive(i, 1'b1, op, a, b);
        @(negedge clk);
        drive(i, 1'b0, op, a, b);
        @(negedge clk);
        drive(i, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic wait_done(input int i, input int budget, input string name, output int n);
        n = 0;
        while (f_done(i) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, " done_timeout"}, {63'b0, f_done(i)}, 64'd1);
    endtask

    typedef struct {
        int          u;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        c;
        logic        ov;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        drive(0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 3'd0, 64'd0, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_result", f_res(i), 64'd0);
            chk("reset_flags", {58'b0, f_c(i), f_ov(i), f_err(i), f_done(i), f_busy(i), 1'b0}, 64'd0);
        end
        reset = 1'b0;

        vecs.push_back('{0, 3'd0, 64'hFFFFFFFF, 64'd1,          64'h0,        1, 0, 0});
        vecs.push_back('{0, 3'd1, 64'h80000000, 64'd1,          64'h7FFFFFFF, 0, 1, 0});
        vecs.push_back('{0, 3'd5, 64'hFFFFFFFF, 64'd0,          64'h1,        0, 0, 0});
        vecs.push_back('{0, 3'd0, 64'h7FFFFFFF, 64'd1,          64'h80000000, 0, 1, 0});
        vecs.push_back('{0, 3'd1, 64'h0,        64'd1,          64'hFFFFFFFF, 1, 0, 0});
        vecs.push_back('{0, 3'd2, 64'hF0F0F0F0, 64'h0FF00FF0,   64'h00F000F0, 0, 0, 0});
        vecs.push_back('{0, 3'd3, 64'h12340000, 64'h00005678,   64'h12345678, 0, 0, 0});
        vecs.push_back('{0, 3'd4, 64'hFFFF0000, 64'h0F0F0F0F,   64'hF0F00F0F, 0, 0, 0});
        vecs.push_back('{0, 3'd5, 64'h5,        64'hFFFFFFFF,   64'h0,        0, 0, 0});
        vecs.push_back('{0, 3'd5, 64'h80000000, 64'h7FFFFFFF,   64'h1,        0, 0, 0});
        vecs.push_back('{0, 3'd7, 64'h1234,     64'h5678,       64'h0,        0, 0, 1});
        vecs.push_back('{0, 3'd6, 64'h3,        64'h5,          MUL_EN ? 64'd15 : 64'd0, 0, 0, !MUL_EN});
        vecs.push_back('{1, 3'd6, 64'h10,       64'h11,         MUL_EN ? 64'h10 : 64'd0, MUL_EN, 0, !MUL_EN});
        vecs.push_back('{1, 3'd6, 64'hFF,       64'hFF,         MUL_EN ? 64'h01 : 64'd0, MUL_EN, 0, !MUL_EN});
        vecs.push_back('{1, 3'd6, 64'h0F,       64'h0F,         MUL_EN ? 64'hE1 : 64'd0, 0, 0, !MUL_EN});
        vecs.push_back('{1, 3'd0, 64'h7F,       64'h01,         64'h80,       0, 1, 0});
        vecs.push_back('{1, 3'd1, 64'h03,       64'h05,         64'hFE,       1, 0, 0});

        foreach (vecs[k]) begin
            issue(vecs[k].u, vecs[k].op, vecs[k].a, vecs[k].b);
            chk($sformatf("v%0d done_low_after_latch", k), {63'b0, f_done(vecs[k].u)}, 64'd0);
            wait_done(vecs[k].u, 40, $sformatf("v%0d", k), n);
            lat = (vecs[k].op == 3'd6 && MUL_EN) ? ((vecs[k].u == 0) ? W0 + 1 : W1 + 1) : 1;
            chk($sformatf("v%0d latency", k), 64'(n), 64'(lat));
            chk($sformatf("v%0d result", k), f_res(vecs[k].u), vecs[k].res);
            chk($sformatf("v%0d c_ov_err", k),
                {61'b0, f_c(vecs[k].u), f_ov(vecs[k].u), f_err(vecs[k].u)},
                {61'b0, vecs[k].c, vecs[k].ov, vecs[k].err});
        end

        // start re-pulsed while busy must be ignored
        issue(1, 3'd6, 64'd7, 64'd9);
        drive(1, 1'b1, 3'd0, 64'd1, 64'd1);
        @(negedge clk);
        drive(1, 1'b0, 3'd0, 64'd1, 64'd1);
        if (MUL_EN) begin
            repeat (2) @(negedge clk);
            chk("repulse busy", {63'b0, f_busy(1)}, 64'd1);
            drive(1, 1'b1, 3'd0, 64'd1, 64'd1);
            @(negedge clk);
            drive(1, 1'b0, 3'd0, 64'd1, 64'd1);
        end
        wait_done(1, 20, "repulse", n);
        repeat (3) @(negedge clk);
        chk("repulse idle_busy", {63'b0, f_busy(1)}, 64'd0);
        chk("repulse result", f_res(1), MUL_EN ? 64'd63 : 64'd0);
        chk("repulse err", {63'b0, f_err(1)}, MUL_EN ? 64'd0 : 64'd1);

        // start held high: back-to-back requests
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 64'd3, 64'd4);
        repeat (10) @(negedge clk);
        drive(0, 1'b0, 3'd0, 64'd3, 64'd4);
        repeat (4) @(negedge clk);
        chk("held_start result", f_res(0), 64'd7);
        chk("held_start busy", {63'b0, f_busy(0)}, 64'd0);

        // reset mid-operation, then a fresh ADD
        issue(1, 3'd6, 64'h10, 64'h11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {63'b0, f_busy(1)}, 64'd0);
        chk("abort done", {63'b0, f_done(1)}, 64'd0);
        chk("abort result", f_res(1), 64'd0);
        repeat (12) @(negedge clk);
        chk("abort no_late_done", {63'b0, f_done(1)}, 64'd0);
        issue(1, 3'd0, 64'd3, 64'd4);
        wait_done(1, 10, "post_reset_add", n);
        chk("post_reset_add result", f_res(1), 64'd7);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_unit_seq.md
ARITH_UNIT_SEQ -- requirements
Module: arith_unit_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation code, captured with operands.
REQ-006 a  input  WIDTH  operand A, captured with op.
REQ-007 b  input  WIDTH  operand B, captured with op.
REQ-008 result  output  WIDTH  registered result.
REQ-009 carry  output  1  ADD carry-out / SUB borrow / MUL high-half-nonzero.
REQ-010 overflow  output  1  signed overflow for ADD/SUB.
REQ-011 err  output  1  unsupported op code for the captured request.
REQ-012 done  output  1  result valid; level, held until next capture.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, LATCH, EXEC, MUL; IDLE->LATCH when start=1, else stay IDLE.
REQ-015 LATCH: capture op, a, b into internal registers; done<=0, err<=0; next EXEC.
REQ-016 EXEC, single-cycle ops: write result, carry, overflow, err; done<=1; next IDLE.
REQ-017 Latency single-cycle ops: start sampled at edge N -> done=1 after edge N+2.
REQ-018 Op codes: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SLT (signed a<b -> result 1 else 0), 110 MUL, 111 reserved.
REQ-019 ADD/SUB: result modulo 2^WIDTH; carry = bit WIDTH of a+b (ADD) or unsigned a<b (SUB); overflow = two's-complement signed overflow.
REQ-020 AND/OR/XOR/SLT: carry=0, overflow=0.
REQ-021 Invalid op (111, or 110 without MUL): result=0, carry=0, overflow=0, err=1, done=1, latency per REQ-017.
REQ-022 MUL: EXEC clears accumulator and enters MUL; MUL performs one shift-add step per cycle for exactly WIDTH cycles, then writes result, done<=1, next IDLE.
REQ-023 MUL latency: done=1 after edge N+2+WIDTH; result = low WIDTH bits of unsigned product; carry=1 iff high WIDTH bits nonzero; overflow=0.
REQ-024 start while busy=1 ignored, no queueing; a/b/op changes after LATCH have no effect.
REQ-025 start held high continuously: new request accepted in the IDLE cycle following each completion; done drops at that LATCH edge.
REQ-026 Outputs hold last values in IDLE until next LATCH.

Reset
REQ-027 reset=1 at a posedge forces IDLE; result=0, carry=0, overflow=0, err=0, done=0, busy=0.
REQ-028 reset during LATCH/EXEC/MUL aborts the operation; no done pulse for it; reset dominates start.

Configuration
REQ-029 Macro ARITH_UNIT_SEQ_MUL_EN defined: MUL state and shift-add datapath compiled in, op 110 per REQ-022/023.
REQ-030 Macro undefined: no MUL state or multiplier logic; op 110 treated as invalid per REQ-021.

Verification
REQ-031 WIDTH=32, ADD a=0xFFFFFFFF b=1 -> result=0, carry=1, overflow=0, done after 2 edges.
REQ-032 WIDTH=32, SUB a=0x80000000 b=1 -> result=0x7FFFFFFF, carry=0, overflow=1; SLT a=0xFFFFFFFF b=0 -> result=1.
REQ-033 MUL_EN defined, WIDTH=8, a=0x10 b=0x11 -> result=0x10, carry=1, done after 10 edges; undefined -> err=1, result=0.
REQ-034 start re-pulsed during MUL -> ignored, busy stays 1, single done for the original request.
REQ-035 reset asserted mid-MUL -> next cycle busy=0, done=0, result=0; fresh ADD 3+4 then gives result=7.
